// File: rtl/monitor_fifo_arbiter_pkg.sv
// Shared constants, FSM encoding and a width helper for the monitor FIFO arbiter.
package monitor_fifo_arbiter_pkg;

  localparam int MON_DATA_W    = 128;
  localparam int MON_TIME_W    = 32;
  localparam int MON_PAYLOAD_W = 96;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  // Index width for n items, never less than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/monitor_fifo_arbiter_if.sv
// Bus between the monitor shifters, the arbiter and the downstream consumer.
interface monitor_fifo_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 128
);
  import monitor_fifo_arbiter_pkg::*;

  localparam int CH_W = clog2(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] MON_DATA;
  logic [NUM_CH-1:0]        MON_EMPTY;
  logic [NUM_CH-1:0]        MON_READ;
  logic [DATA_W-1:0]        OUT_DATA;
  logic [CH_W-1:0]          OUT_CHANNEL;
  logic                     OUT_VALID;
  logic                     OUT_READY;

  modport master (
    input  MON_DATA, MON_EMPTY, OUT_READY,
    output MON_READ, OUT_DATA, OUT_CHANNEL, OUT_VALID
  );

  modport slave (
    output MON_DATA, MON_EMPTY, OUT_READY,
    input  MON_READ, OUT_DATA, OUT_CHANNEL, OUT_VALID
  );

endinterface

// File: rtl/monitor_fifo_arbiter_rr_priority_select.sv
// Round-robin pick: first requesting index at or after ptr, wrapping modulo NUM_CH.
module rr_priority_select
  import monitor_fifo_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              any,
  output logic [CH_W-1:0]   idx
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic [CH_W-1:0]     off;
  logic [CH_W:0]       sum;
  logic                found;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NUM_CH'(req_dbl >> ptr);
    off     = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_rot[i]) begin
        off   = CH_W'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
    idx = sum[CH_W-1:0];
    any = |req;
  end

endmodule

// File: rtl/monitor_fifo_arbiter.sv
// Round-robin sequencer pulling one word per grant from the monitor shifters
// and presenting it, tagged with its source channel, on a valid/ready port.
module monitor_fifo_arbiter
  import monitor_fifo_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = MON_DATA_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_CH-1:0]   CH_ENABLE,
  monitor_fifo_arbiter_if.master bus,
  output logic [15:0]         XFER_COUNT,
  output logic                BUSY
);

  localparam int CH_W = clog2(NUM_CH);

  arb_state_e          state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]     out_channel_q, out_channel_d;
  logic                out_valid_q, out_valid_d;
  logic [15:0]         xfer_count_q, xfer_count_d;

  logic [NUM_CH-1:0]   request;
  logic                pick_any;
  logic [CH_W-1:0]     pick_idx;
  logic [NUM_CH-1:0]   mon_read;
  logic                busy;

  assign request = CH_ENABLE & ~bus.MON_EMPTY;

  rr_priority_select #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req (request),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // State and datapath registers; reset drops any in-flight word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      xfer_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      xfer_count_q  <= xfer_count_d;
    end
  end

  // Next state: grant in IDLE, capture in READ, wait for the handshake in HOLD.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    xfer_count_d  = xfer_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        out_data_d    = bus.MON_DATA[int'(grant_q)*DATA_W +: DATA_W];
        out_channel_d = grant_q;
        out_valid_d   = 1'b1;
        state_d       = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && bus.OUT_READY) begin
          out_valid_d  = 1'b0;
          xfer_count_d = xfer_count_q + 16'd1;
          rr_ptr_d     = (grant_q == CH_W'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only; held quiet while RESET is high.
  always_comb begin
    mon_read = '0;
    busy     = 1'b0;
    if (!RESET) begin
      if (state_q == ST_READ) mon_read = NUM_CH'(1) << grant_q;
      busy = (state_q != ST_IDLE);
    end
  end

  assign bus.MON_READ    = mon_read;
  assign bus.OUT_DATA    = out_data_q;
  assign bus.OUT_CHANNEL = out_channel_q;
  assign bus.OUT_VALID   = out_valid_q;
  assign XFER_COUNT      = xfer_count_q;
  assign BUSY            = busy;

endmodule

// File: tb/tb_monitor_fifo_arbiter.sv
// Bench for monitor_fifo_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level round-robin model.
module tb_monitor_fifo_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_enable;
  logic [15:0] xfer_count;
  logic        busy;

  monitor_fifo_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  monitor_fifo_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .CH_ENABLE  (ch_enable),
    .bus        (bus),
    .XFER_COUNT (xfer_count),
    .BUSY       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: one word in flight at a time, picked round-robin.
  bit             m_inflight;
  int             m_age;      // 1 = read strobe cycle, 2 = word on output
  int             m_g;
  int             m_ptr;
  int             m_ch;
  int             m_cnt;
  logic [127:0]   m_data;

  int  grant_log[$];
  bit  prev_valid;

  function automatic int rr_pick(input logic [3:0] req, input int start);
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (start + k) % NUM_CH;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [3:0] req;
    req = ch_enable & ~bus.MON_EMPTY;
    if (rst) begin
      m_inflight = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
      m_data = '0;
      m_ch   = 0;
    end else if (!m_inflight) begin
      if (req != 4'd0) begin
        m_g        = rr_pick(req, m_ptr);
        m_inflight = 1'b1;
        m_age      = 1;
      end
    end else if (m_age == 1) begin
      m_data = bus.MON_DATA[m_g*DATA_W +: DATA_W];
      m_ch   = m_g;
      m_age  = 2;
    end else if (bus.OUT_READY) begin
      m_cnt      = (m_cnt + 1) % 65536;
      m_ptr      = (m_g + 1) % NUM_CH;
      m_inflight = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_read;
    exp_read = (m_inflight && m_age == 1) ? 4'(1 << m_g) : 4'd0;
    check_val("mon_read",    bus.MON_READ, exp_read);
    check_val("read_onehot", ($countones(bus.MON_READ) <= 1), 1);
    check_val("out_valid",   bus.OUT_VALID, (m_inflight && m_age == 2));
    check_val("busy",        busy, m_inflight);
    check_val("out_channel", bus.OUT_CHANNEL, m_ch);
    check_val("out_data",    bus.OUT_DATA, m_data);
    check_val("xfer_count",  xfer_count, m_cnt);
    if (bus.OUT_VALID === 1'b1 && !prev_valid) grant_log.push_back(int'(bus.OUT_CHANNEL));
    prev_valid = (bus.OUT_VALID === 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_data();
    for (int c = 0; c < NUM_CH; c++)
      bus.MON_DATA[c*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    grant_log.delete();
  endtask

  initial begin
    int exp2[6] = '{0, 1, 2, 3, 0, 1};
    int exp4[4] = '{1, 3, 1, 3};

    rst           = 1'b1;
    ch_enable     = 4'h0;
    bus.MON_EMPTY = 4'hF;
    bus.MON_DATA  = '0;
    bus.OUT_READY = 1'b0;
    prev_valid    = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_val("rst_count", xfer_count, 16'd0);
    check_val("rst_valid", bus.OUT_VALID, 1'b0);

    // Single word from channel 1
    ch_enable     = 4'hF;
    bus.MON_EMPTY = 4'b1101;
    bus.MON_DATA[1*DATA_W +: DATA_W] = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501;
    bus.OUT_READY = 1'b1;
    step();
    check_val("t1_read", bus.MON_READ, 4'b0010);
    bus.MON_EMPTY = 4'hF;
    step();
    check_val("t1_valid", bus.OUT_VALID, 1'b1);
    check_val("t1_chan",  bus.OUT_CHANNEL, 2'd1);
    check_val("t1_data",  bus.OUT_DATA, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501);
    step();
    check_val("t1_count", xfer_count, 16'd1);

    // Round robin with all channels requesting
    do_reset();
    ch_enable = 4'hF; bus.MON_EMPTY = 4'h0; bus.OUT_READY = 1'b1;
    for (int i = 0; i < 18; i++) begin rand_data(); step(); end
    check_val("t2_count", xfer_count, 16'd6);
    check_val("t2_len", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check_val("t2_order", grant_log[i], exp2[i]);

    // Backpressure on channel 2
    do_reset();
    bus.MON_EMPTY = 4'b1011; bus.OUT_READY = 1'b0;
    step(); step();
    check_val("t3_valid", bus.OUT_VALID, 1'b1);
    for (int i = 0; i < 20; i++) begin
      rand_data();
      bus.MON_EMPTY = 4'($urandom);
      step();
      check_val("t3_chan", bus.OUT_CHANNEL, 2'd2);
      check_val("t3_noread", bus.MON_READ, 4'd0);
    end
    bus.MON_EMPTY = 4'hF;
    bus.OUT_READY = 1'b1;
    step();
    check_val("t3_count", xfer_count, 16'd1);
    check_val("t3_idle", busy, 1'b0);

    // Enable mask 1010
    do_reset();
    ch_enable = 4'b1010; bus.MON_EMPTY = 4'h0; bus.OUT_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin rand_data(); step(); end
    check_val("t4_len", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check_val("t4_order", grant_log[i], exp4[i]);
    // Drop ch3 enable while its word is held
    do_reset();
    step(); step(); step();
    bus.OUT_READY = 1'b0;
    step(); step();
    check_val("t4_hold3", bus.OUT_CHANNEL, 2'd3);
    ch_enable = 4'b0010;
    step(); step();
    bus.OUT_READY = 1'b1;
    step();
    check_val("t4_count", xfer_count, 16'd2);

    // Reset while a word is held
    do_reset();
    ch_enable = 4'hF; bus.MON_EMPTY = 4'h0; bus.OUT_READY = 1'b1;
    step(); step(); step();
    bus.OUT_READY = 1'b0;
    step(); step();
    check_val("t5_pre_valid", bus.OUT_VALID, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t5_valid", bus.OUT_VALID, 1'b0);
    check_val("t5_busy",  busy, 1'b0);
    check_val("t5_count", xfer_count, 16'd0);
    step();
    check_val("t5_first", bus.MON_READ, 4'b0001);
    bus.OUT_READY = 1'b1;
    step(); step();

    // Counter wrap and pointer wrap after channel 3
    bus.MON_EMPTY = 4'hF;
    step(); step();
    force dut.xfer_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #2;
    release dut.xfer_count_q;
    step();
    check_val("t6_preload", xfer_count, 16'hFFFE);
    bus.MON_EMPTY = 4'b0111;
    grant_log.delete();
    step(); step(); step();
    check_val("t6_ffff", xfer_count, 16'hFFFF);
    bus.MON_EMPTY = 4'h0;
    step(); step(); step();
    check_val("t6_wrap", xfer_count, 16'h0000);
    check_val("t6_len", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check_val("t6_g3", grant_log[0], 3);
      check_val("t6_g0", grant_log[1], 0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      ch_enable     = 4'($urandom);
      bus.MON_EMPTY = 4'($urandom);
      bus.OUT_READY = ($urandom_range(0, 2) != 0);
      rand_data();
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
